pi_dac_driver: RTL and testbench
================================

Name: pi_dac_driver

Overview:
- Actuator end of the PI loop: consumes the PI controller's pi_output/pi_output_valid stream.
- Applies a range clamp and a per-sample slew limit, then converts the result to offset-binary.
- Serialises each update to an external SPI DAC (24-bit frame: 8-bit command + 16-bit code).
- Returns pi_limiting to the PI controller, so its integrator freezes (anti-windup) whenever the actuator did not apply the requested value.

Parameters:
- DATA_WIDTH, 16, width of pi_output and DAC code; input format Q1.15 signed.
- CMD_BITS, 8, width of the command prefix shifted before the data.
- DAC_CMD, 8'h30, command value sent in every frame (write-and-update).
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.
- GAP_CYCLES, 4, minimum clk cycles CS_n stays high between frames; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pi_output  in  DATA_WIDTH  signed Q1.15 sample from the PI controller.
- pi_output_valid  in  1  sample strobe; may be held high continuously.
- out_min  in  DATA_WIDTH  signed lower clamp bound (Q1.15).
- out_max  in  DATA_WIDTH  signed upper clamp bound (Q1.15); out_min ≤ out_max is required.
- slew_max  in  DATA_WIDTH  unsigned maximum |step| per update; 0 disables slew limiting.
- pi_limiting  out  1  high when the last applied value differs from the requested pi_output.
- busy  out  1  high from sample acceptance until the end of the inter-frame gap.
- sample_dropped  out  1  one-cycle pulse when a pending sample is overwritten.
- dac_update  out  1  one-cycle pulse on the cycle CS_n returns high.
- applied_value  out  DATA_WIDTH  signed value of the last completed frame.
- dac_sclk  out  1  SPI clock, idle low (mode 0).
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sdi  out  1  SPI data, MSB first.

Behaviour:
- Reset values: pi_limiting=0, busy=0, sample_dropped=0, dac_update=0, applied_value=0, dac_sclk=0, dac_cs_n=1, dac_sdi=0. Internal last value=0, pending register empty, state=IDLE.
- Reset mid-frame aborts immediately on the next edge: CS_n goes high and no dac_update is issued.

Sample intake:
- When pi_output_valid is high, the sample is latched into a 1-deep pending register.
- If the pending register is already full and not consumed that cycle, the old sample is overwritten and sample_dropped pulses.
- In IDLE, a valid pending sample is consumed on the following cycle.

State IDLE -> CALC (2 cycles):
- Cycle 1: target = min(max(sample, out_min), out_max). clamp_hit = (target ≠ sample).
- Cycle 2: delta = target − last, computed at DATA_WIDTH+1 bits. If slew_max≠0 and |delta|>slew_max, then delta = ±slew_max and slew_hit=1. next = last + delta, which cannot overflow since it lies between last and target.
- On leaving CALC: shift register = {DAC_CMD, next ^ (1<<(DATA_WIDTH−1))}; dac_cs_n←0; last←next.

State SHIFT:
- CMD_BITS+DATA_WIDTH bits are sent.
- Each bit has an SCLK-low phase of CLK_DIV cycles followed by an SCLK-high phase of CLK_DIV cycles.
- dac_sdi updates at the start of each low phase and is stable across the rising edge.
- Frame length = 2·CLK_DIV·(CMD_BITS+DATA_WIDTH) cycles, i.e. 96 with the defaults.
- After the last high phase: dac_sclk←0, dac_cs_n←1, dac_update pulses, applied_value←next, pi_limiting←clamp_hit|slew_hit.

State GAP:
- CS_n held high for GAP_CYCLES cycles, then → IDLE.
- busy drops on the cycle the state enters IDLE.
- A sample pending at that point is consumed the next cycle.

Other rules:
- pi_limiting is held until the next dac_update.
- Bound or slew_max changes take effect only at the next CALC.
- Simultaneous pi_output_valid and consumption of the pending register: the new sample fills the register and no drop is flagged.

Test Plan:
- Reset, then a single sample 0x2000 with out_min=0x8000, out_max=0x7FFF, slew_max=0 → one 24-bit frame 0x30A000, MSB first. dac_update fires at cycle 2+96 after acceptance; applied_value=0x2000; pi_limiting=0.
- Clamp: out_max=0x4000, sample 0x6000 → frame data 0xC000, applied_value=0x4000, pi_limiting=1. Next sample 0x1000 → pi_limiting=0 after its frame.
- Slew: last=0, slew_max=0x0100, sample 0x0800 → applied 0x0100, then 0x0200 and 0x0300 on successive frames with pi_limiting=1. Negative sample 0xF000 from 0x0300 → 0x0200.
- Backpressure: valid held high with values 1,2,3,… during a frame → only the latest value is sent next. sample_dropped pulses once per overwritten sample; no frame is ever shorter than 96 cycles and the gap is ≥4 cycles.
- SPI timing check (CLK_DIV=3): SCLK half-period is exactly 3 cycles; SDI is stable from its falling-edge update through the rising edge; CS_n low spans exactly 144 cycles.
- Reset asserted at bit 10 of a frame → next cycle CS_n=1, SCLK=0, no dac_update, applied_value=0. A subsequent sample slews from 0.

Source files
------------

// File: rtl/pi_dac_driver.sv
// Actuator end of the PI loop: clamps and slew-limits each controller sample,
// converts it to offset-binary and shifts it to an SPI DAC (mode 0, MSB first).
module pi_dac_driver #(
  parameter int unsigned         DATA_WIDTH = 16,
  parameter int unsigned         CMD_BITS   = 8,
  parameter logic [CMD_BITS-1:0] DAC_CMD    = CMD_BITS'(8'h30),
  parameter int unsigned         CLK_DIV    = 2,
  parameter int unsigned         GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pi_output,
  input  logic                  pi_output_valid,
  input  logic [DATA_WIDTH-1:0] out_min,
  input  logic [DATA_WIDTH-1:0] out_max,
  input  logic [DATA_WIDTH-1:0] slew_max,
  output logic                  pi_limiting,
  output logic                  busy,
  output logic                  sample_dropped,
  output logic                  dac_update,
  output logic [DATA_WIDTH-1:0] applied_value,
  output logic                  dac_sclk,
  output logic                  dac_cs_n,
  output logic                  dac_sdi
);

  localparam int unsigned FRAME_BITS = CMD_BITS + DATA_WIDTH;
  localparam int unsigned EXT_W      = DATA_WIDTH + 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned DIV_W      = 8;
  localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CALC1, S_CALC2, S_SHIFT, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic                    pend_full_q, pend_full_d;
  logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic [DATA_WIDTH-1:0]   target_q, target_d;
  logic                    clamp_hit_q, clamp_hit_d;
  logic [DATA_WIDTH-1:0]   last_q, last_d;
  logic [DATA_WIDTH-1:0]   next_q, next_d;
  logic                    limit_q, limit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    phase_q, phase_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    busy_q, busy_d;
  logic                    sample_dropped_q, sample_dropped_d;
  logic                    dac_update_q, dac_update_d;
  logic [DATA_WIDTH-1:0]   applied_value_q, applied_value_d;
  logic                    pi_limiting_q, pi_limiting_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sdi_q, sdi_d;

  logic consume, div_end, last_bit, frame_end, gap_end;

  assign consume   = (state_q == S_IDLE) && pend_full_q;
  assign div_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit  = (bit_q == BIT_W'(FRAME_BITS - 1));
  assign frame_end = (state_q == S_SHIFT) && div_end && phase_q && last_bit;
  assign gap_end   = (gap_q == GAP_W'(GAP_CYCLES - 1));

  // Range clamp (first CALC cycle)
  logic signed [DATA_WIDTH-1:0] sample_s, min_s, max_s, floor_s, clamped_s;
  assign sample_s  = $signed(sample_q);
  assign min_s     = $signed(out_min);
  assign max_s     = $signed(out_max);
  assign floor_s   = (sample_s < min_s) ? min_s : sample_s;
  assign clamped_s = (floor_s > max_s) ? max_s : floor_s;

  // Slew limit (second CALC cycle); the wrapped sum is exact because it lies between last and target
  logic signed [EXT_W-1:0]  delta_raw;
  logic                     delta_neg, slew_hit;
  logic [EXT_W-1:0]         delta_mag, slew_ext;
  logic [DATA_WIDTH-1:0]    delta_lim, next_val;
  logic [FRAME_BITS-1:0]    frame;

  assign delta_raw = $signed({target_q[DATA_WIDTH-1], target_q}) - $signed({last_q[DATA_WIDTH-1], last_q});
  assign delta_neg = delta_raw[EXT_W-1];
  assign delta_mag = delta_neg ? $unsigned(-delta_raw) : $unsigned(delta_raw);
  assign slew_ext  = {1'b0, slew_max};
  assign slew_hit  = (slew_max != '0) && (delta_mag > slew_ext);
  assign delta_lim = !slew_hit ? $unsigned(delta_raw[DATA_WIDTH-1:0])
                   : (delta_neg ? (~slew_max + DATA_WIDTH'(1)) : slew_max);
  assign next_val  = last_q + delta_lim;
  assign frame     = {DAC_CMD, next_val ^ SIGN_BIT};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      pend_full_q      <= 1'b0;
      pend_data_q      <= '0;
      sample_q         <= '0;
      target_q         <= '0;
      clamp_hit_q      <= 1'b0;
      last_q           <= '0;
      next_q           <= '0;
      limit_q          <= 1'b0;
      shift_q          <= '0;
      div_q            <= '0;
      phase_q          <= 1'b0;
      bit_q            <= '0;
      gap_q            <= '0;
      busy_q           <= 1'b0;
      sample_dropped_q <= 1'b0;
      dac_update_q     <= 1'b0;
      applied_value_q  <= '0;
      pi_limiting_q    <= 1'b0;
      sclk_q           <= 1'b0;
      cs_n_q           <= 1'b1;
      sdi_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_full_q      <= pend_full_d;
      pend_data_q      <= pend_data_d;
      sample_q         <= sample_d;
      target_q         <= target_d;
      clamp_hit_q      <= clamp_hit_d;
      last_q           <= last_d;
      next_q           <= next_d;
      limit_q          <= limit_d;
      shift_q          <= shift_d;
      div_q            <= div_d;
      phase_q          <= phase_d;
      bit_q            <= bit_d;
      gap_q            <= gap_d;
      busy_q           <= busy_d;
      sample_dropped_q <= sample_dropped_d;
      dac_update_q     <= dac_update_d;
      applied_value_q  <= applied_value_d;
      pi_limiting_q    <= pi_limiting_d;
      sclk_q           <= sclk_d;
      cs_n_q           <= cs_n_d;
      sdi_q            <= sdi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (consume) state_d = S_CALC1;
      S_CALC1: state_d = S_CALC2;
      S_CALC2: state_d = S_SHIFT;
      S_SHIFT: if (frame_end) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_full_d      = pend_full_q;
    pend_data_d      = pend_data_q;
    sample_d         = sample_q;
    target_d         = target_q;
    clamp_hit_d      = clamp_hit_q;
    last_d           = last_q;
    next_d           = next_q;
    limit_d          = limit_q;
    shift_d          = shift_q;
    div_d            = div_q;
    phase_d          = phase_q;
    bit_d            = bit_q;
    gap_d            = gap_q;
    sample_dropped_d = 1'b0;
    dac_update_d     = 1'b0;
    applied_value_d  = applied_value_q;
    pi_limiting_d    = pi_limiting_q;
    sclk_d           = sclk_q;
    cs_n_d           = cs_n_q;
    sdi_d            = sdi_q;
    busy_d           = (state_d != S_IDLE);

    // A new sample always wins the pending slot; losing an unconsumed one is flagged
    if (pi_output_valid) begin
      pend_data_d      = pi_output;
      pend_full_d      = 1'b1;
      sample_dropped_d = pend_full_q && !consume;
    end else if (consume) begin
      pend_full_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (consume) sample_d = pend_data_q;
      end
      S_CALC1: begin
        target_d    = $unsigned(clamped_s);
        clamp_hit_d = (clamped_s != sample_s);
      end
      S_CALC2: begin
        last_d  = next_val;
        next_d  = next_val;
        limit_d = clamp_hit_q | slew_hit;
        shift_d = frame;
        sdi_d   = frame[FRAME_BITS-1];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
      end
      S_SHIFT: begin
        if (!div_end) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (last_bit) begin
              cs_n_d          = 1'b1;
              sdi_d           = 1'b0;
              dac_update_d    = 1'b1;
              applied_value_d = next_q;
              pi_limiting_d   = limit_q;
              gap_d           = '0;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = shift_q << 1;
              sdi_d   = shift_q[FRAME_BITS-2];
            end
          end
        end
      end
      S_GAP: begin
        if (!gap_end) gap_d = gap_q + GAP_W'(1);
      end
      default: ;
    endcase
  end

  assign pi_limiting    = pi_limiting_q;
  assign busy           = busy_q;
  assign sample_dropped = sample_dropped_q;
  assign dac_update     = dac_update_q;
  assign applied_value  = applied_value_q;
  assign dac_sclk       = sclk_q;
  assign dac_cs_n       = cs_n_q;
  assign dac_sdi        = sdi_q;

endmodule

// File: tb/tb_pi_dac_driver.sv
// Bench for pi_dac_driver: a default instance checked against a clamp/slew reference
// model through a scoreboard, plus a CLK_DIV=3 instance checked for SPI framing.
module tb_pi_dac_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pi_output = '0;
  logic        pi_output_valid = 1'b0;
  logic [15:0] out_min = 16'h8000;
  logic [15:0] out_max = 16'h7FFF;
  logic [15:0] slew_max = 16'h0000;

  logic        lim0, busy0, drop0, upd0, sclk0, cs0, sdi0;
  logic [15:0] applied0;
  logic        lim1, busy1, drop1, upd1, sclk1, cs1, sdi1;
  logic [15:0] applied1;

  pi_dac_driver u_dut (
    .clk(clk), .reset(reset), .pi_output(pi_output), .pi_output_valid(pi_output_valid),
    .out_min(out_min), .out_max(out_max), .slew_max(slew_max),
    .pi_limiting(lim0), .busy(busy0), .sample_dropped(drop0), .dac_update(upd0),
    .applied_value(applied0), .dac_sclk(sclk0), .dac_cs_n(cs0), .dac_sdi(sdi0)
  );

  pi_dac_driver #(.CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .pi_output(pi_output), .pi_output_valid(pi_output_valid),
    .out_min(out_min), .out_max(out_max), .slew_max(slew_max),
    .pi_limiting(lim1), .busy(busy1), .sample_dropped(drop1), .dac_update(upd1),
    .applied_value(applied1), .dac_sclk(sclk1), .dac_cs_n(cs1), .dac_sdi(sdi1)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  bit     rst_d1  = 1'b1;
  int     drop_cnt = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= reset;
  end

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: clamp to [min,max], then move at most slew_max from the last value
  typedef struct {
    logic [23:0] frame;
    logic [15:0] applied;
    logic        lim;
    longint      due;
  } exp_t;

  exp_t sb[$];
  int   m_last = 0;

  function automatic exp_t model(input logic [15:0] s, input longint due);
    int smp, lo, hi, tgt, d, sl, nxt;
    exp_t e;
    logic [15:0] code;
    smp = int'($signed(s));
    lo  = int'($signed(out_min));
    hi  = int'($signed(out_max));
    tgt = (smp < lo) ? lo : smp;
    if (tgt > hi) tgt = hi;
    d  = tgt - m_last;
    sl = int'(slew_max);
    if (sl != 0 && (d > sl || d < -sl)) d = (d > 0) ? sl : -sl;
    nxt    = m_last + d;
    m_last = nxt;
    code      = 16'(nxt);
    e.frame   = {8'h30, code ^ 16'h8000};
    e.applied = code;
    e.lim     = (nxt != smp);
    e.due     = due;
    return e;
  endfunction

  // SPI monitor for both instances; instance 0 also drains the scoreboard
  logic [1:0]  cs_v, sclk_v, sdi_v, upd_v;
  assign cs_v   = {cs1, cs0};
  assign sclk_v = {sclk1, sclk0};
  assign sdi_v  = {sdi1, sdi0};
  assign upd_v  = {upd1, upd0};

  int          lo_run[2], lvl_run[2], hi_run[2], nbits[2];
  logic [23:0] bits[2];
  logic        prev_cs[2], prev_sclk[2], prev_sdi[2];
  bit          framed[2];
  int          div_of[2] = '{2, 3};
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_d1 && drop0) drop_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (rst_d1) begin
        prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_sdi[i] = 1'b0;
        framed[i] = 1'b0; hi_run[i] = 0; lo_run[i] = 0; nbits[i] = 0;
      end else begin
        if (upd_v[i] && !(cs_v[i] && !prev_cs[i]))
          chk(1'b0, $sformatf("stray_update[%0d]", i), 1, 0);
        if (!cs_v[i]) begin
          if (prev_cs[i]) begin
            if (framed[i]) chk(hi_run[i] >= 4, $sformatf("gap[%0d]", i), hi_run[i], 4);
            chk(sclk_v[i] == 1'b0, $sformatf("sclk_at_cs_fall[%0d]", i), sclk_v[i], 0);
            if (i == 0) chk(busy0 == 1'b1, "busy_in_frame", busy0, 1);
            lo_run[i] = 1; lvl_run[i] = 1; nbits[i] = 0; bits[i] = '0;
          end else begin
            lo_run[i]++;
            if (sclk_v[i] != prev_sclk[i]) begin
              chk(lvl_run[i] == div_of[i], $sformatf("half_period[%0d]", i), lvl_run[i], div_of[i]);
              lvl_run[i] = 1;
              if (sclk_v[i]) begin
                bits[i] = {bits[i][22:0], sdi_v[i]};
                nbits[i]++;
              end
            end else begin
              lvl_run[i]++;
            end
            if (sdi_v[i] != prev_sdi[i])
              chk(prev_sclk[i] && !sclk_v[i], $sformatf("sdi_stable[%0d]", i), sclk_v[i], 0);
          end
        end else if (!prev_cs[i]) begin
          hi_run[i] = 1;
          chk(upd_v[i] == 1'b1, $sformatf("update_at_cs_rise[%0d]", i), upd_v[i], 1);
          chk(prev_sclk[i] && !sclk_v[i] && lvl_run[i] == div_of[i],
              $sformatf("last_high_phase[%0d]", i), lvl_run[i], div_of[i]);
          chk(lo_run[i] == 48 * div_of[i], $sformatf("cs_span[%0d]", i), lo_run[i], 48 * div_of[i]);
          chk(nbits[i] == 24, $sformatf("bit_count[%0d]", i), nbits[i], 24);
          chk(bits[i][23:16] == 8'h30, $sformatf("cmd_byte[%0d]", i), bits[i][23:16], 8'h30);
          framed[i] = 1'b1;
          if (i == 0 && upd0) begin
            if (sb.size() == 0) begin
              chk(1'b0, "unexpected_update", applied0, 0);
            end else begin
              mon_e = sb.pop_front();
              chk(bits[0] == mon_e.frame, "frame", bits[0], mon_e.frame);
              chk(applied0 == mon_e.applied, "applied_value", applied0, mon_e.applied);
              chk(lim0 == mon_e.lim, "pi_limiting", lim0, mon_e.lim);
              if (mon_e.due >= 0) chk(cyc == mon_e.due, "update_latency", cyc, mon_e.due);
            end
          end
        end else begin
          hi_run[i]++;
        end
        prev_cs[i] = cs_v[i]; prev_sclk[i] = sclk_v[i]; prev_sdi[i] = sdi_v[i];
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(posedge clk); #1;
    while ((sb.size() != 0 || busy0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) chk(1'b0, "idle_timeout", t, 0);
  endtask

  task automatic set_cfg(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] sl);
    wait_idle();
    out_min = lo; out_max = hi; slew_max = sl;
  endtask

  // Latched at the next edge, consumed one edge later, CS low two edges after that, 96-cycle frame
  task automatic send(input logic [15:0] s);
    wait_idle();
    pi_output = s;
    pi_output_valid = 1'b1;
    sb.push_back(model(s, cyc + 100));
    @(posedge clk); #1;
    pi_output_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    m_last = 0;
  endtask

  initial begin
    int d0;
    logic [15:0] a, b, s;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk(cs0 == 1'b1, "rst_cs_n", cs0, 1);
    chk(sclk0 == 1'b0, "rst_sclk", sclk0, 0);
    chk(sdi0 == 1'b0, "rst_sdi", sdi0, 0);
    chk(busy0 == 1'b0, "rst_busy", busy0, 0);
    chk(upd0 == 1'b0, "rst_update", upd0, 0);
    chk(drop0 == 1'b0, "rst_dropped", drop0, 0);
    chk(applied0 == 16'h0000, "rst_applied", applied0, 0);
    chk(lim0 == 1'b0, "rst_limiting", lim0, 0);
    chk(cs1 == 1'b1, "rst_cs_n_div3", cs1, 1);

    // Plain pass-through, then clamp and its release
    set_cfg(16'h8000, 16'h7FFF, 16'h0000);
    send(16'h2000);
    set_cfg(16'h8000, 16'h4000, 16'h0000);
    send(16'h6000);
    send(16'h1000);

    // Slew limiting from zero, both directions
    wait_idle();
    do_reset();
    set_cfg(16'h8000, 16'h7FFF, 16'h0100);
    send(16'h0800);
    send(16'h0800);
    send(16'h0800);
    send(16'hF000);

    // Backpressure: 40 samples during one frame, only the last survives
    set_cfg(16'h8000, 16'h7FFF, 16'h0000);
    send(16'h0100);
    d0 = drop_cnt;
    repeat (5) begin @(posedge clk); #1; end
    for (int k = 1; k <= 40; k++) begin
      pi_output = 16'(k);
      pi_output_valid = 1'b1;
      @(posedge clk); #1;
    end
    pi_output_valid = 1'b0;
    sb.push_back(model(16'd40, -1));
    wait_idle();
    chk(drop_cnt - d0 == 39, "drop_count", drop_cnt - d0, 39);

    // Reset around bit 10 of a frame aborts it cleanly
    send(16'h1234);
    repeat (43) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(cs0 == 1'b1, "abort_cs_n", cs0, 1);
    chk(sclk0 == 1'b0, "abort_sclk", sclk0, 0);
    chk(upd0 == 1'b0, "abort_update", upd0, 0);
    chk(applied0 == 16'h0000, "abort_applied", applied0, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    m_last = 0;
    repeat (150) @(posedge clk);
    set_cfg(16'h8000, 16'h7FFF, 16'h0100);
    send(16'h0800);

    // Randomized bounds, slew and samples
    for (int n = 0; n < 30; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($signed(a) > $signed(b)) begin s = a; a = b; b = s; end
      if ($urandom_range(0, 3) == 0) begin a = 16'h8000; b = 16'h7FFF; end
      set_cfg(a, b, ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(1, 3000)));
      send(16'($urandom));
    end

    wait_idle();
    for (int t = 0; t < 1000 && busy1; t++) @(posedge clk);
    if (busy1) chk(1'b0, "div3_idle_timeout", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
